// File: rtl/sub_pipe.sv
// sub_pipe: pipelined ripple-borrow subtractor, one CHUNK-bit slice per stage.
// Borrow is registered between slices; flags are formed at the last slice.
module sub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  input  logic             in_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_bout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int PR     = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int MSB    = WIDTH - 1;

  logic             r_vld [PR];
  logic             r_en  [PR];
  logic             r_brw [PR];
  logic [WIDTH-1:0] r_a   [PR];
  logic [WIDTH-1:0] r_b   [PR];
  logic [WIDTH-1:0] r_res [PR];

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_res;
  logic             r_out_bout;
  logic             r_out_zero;
  logic             r_out_neg;
  logic             r_out_ovf;

  logic             w_vld [STAGES];
  logic             w_en  [STAGES];
  logic             w_bi  [STAGES];
  logic             w_bo  [STAGES];
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_ri  [STAGES];
  logic [WIDTH-1:0] w_ro  [STAGES];

  logic             w_stall;
  logic [WIDTH-1:0] w_r;
  logic             w_ovf;

  // Ripple one slice; returns {borrow_out, partial result}.
  function automatic logic [WIDTH:0] f_slice(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r,
    input logic             bi,
    input int               k
  );
    logic [WIDTH-1:0] d;
    logic             bw;
    int               i;
    d  = r;
    bw = bi;
    for (int j = 0; j < CHUNK; j++) begin
      i    = k * CHUNK + j;
      d[i] = a[i] ^ b[i] ^ bw;
      bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    return {bw, d};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_head
      assign w_vld[k] = in_valid;
      assign w_en[k]  = in_enable;
      assign w_a[k]   = in_a;
      assign w_b[k]   = in_b;
      assign w_ri[k]  = '0;
      assign w_bi[k]  = in_bin;
    end else begin : g_body
      assign w_vld[k] = r_vld[k-1];
      assign w_en[k]  = r_en[k-1];
      assign w_a[k]   = r_a[k-1];
      assign w_b[k]   = r_b[k-1];
      assign w_ri[k]  = r_res[k-1];
      assign w_bi[k]  = r_brw[k-1];
    end
    assign {w_bo[k], w_ro[k]} =
      f_slice(w_a[k], w_b[k], w_ri[k], w_bi[k], k);
  end

  assign w_r   = w_ro[STAGES-1];
  assign w_ovf = (w_a[STAGES-1][MSB] != w_b[STAGES-1][MSB]) &
                 (w_r[MSB] != w_a[STAGES-1][MSB]);

  // Whole pipe freezes together when the output is blocked.
  assign w_stall  = r_out_vld & ~out_ready;
  assign in_ready = ~w_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < PR; k++) begin
        r_vld[k] <= 1'b0;
        r_en[k]  <= 1'b0;
        r_brw[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
      end
      r_out_vld  <= 1'b0;
      r_out_res  <= '0;
      r_out_bout <= 1'b0;
      r_out_zero <= 1'b0;
      r_out_neg  <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        r_vld[k] <= w_vld[k];
        r_en[k]  <= w_en[k];
        r_brw[k] <= w_bo[k];
        r_a[k]   <= w_a[k];
        r_b[k]   <= w_b[k];
        r_res[k] <= w_ro[k];
      end
      r_out_vld <= w_vld[STAGES-1];
      // Bubbles leave the result and flags untouched.
      if (w_vld[STAGES-1]) begin
        if (w_en[STAGES-1]) begin
          r_out_res  <= w_r;
          r_out_bout <= w_bo[STAGES-1];
          r_out_zero <= (w_r == '0);
          r_out_neg  <= w_r[MSB];
          r_out_ovf  <= w_ovf;
        end else begin
          r_out_res  <= '0;
          r_out_bout <= 1'b0;
          r_out_zero <= 1'b1;
          r_out_neg  <= 1'b0;
          r_out_ovf  <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_res   = r_out_res;
  assign out_bout  = r_out_bout;
  assign out_zero  = r_out_zero;
  assign out_neg   = r_out_neg;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sub_pipe.sv
// tb_sub_pipe: directed vector table plus streaming, backpressure
// and mid-flight reset sequences for sub_pipe (16-bit, 4 stages).
module tb_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_bin;
  logic        in_enable;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_bout;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;

  always #5 clk = ~clk;

  sub_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_bin(in_bin), .in_enable(in_enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_bout(out_bout),
    .out_zero(out_zero), .out_neg(out_neg),
    .out_ovf(out_ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        en;
    logic [15:0] res;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } vec_t;

  vec_t vt[12];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic [15:0] a, input logic [15:0] b,
    input logic bin, input logic en,
    input logic [15:0] r, input logic bo,
    input logic z, input logic n, input logic o
  );
    vec_t v;
    v.a = a; v.b = b; v.bin = bin; v.en = en;
    v.res = r; v.bout = bo; v.zero = z;
    v.neg = n; v.ovf = o;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    in_a = v.a; in_b = v.b;
    in_bin = v.bin; in_enable = v.en;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'd4);
    chk($sformatf("v%0d_res", idx), 32'(out_res), 32'(v.res));
    chk($sformatf("v%0d_bout", idx), 32'(out_bout), 32'(v.bout));
    chk($sformatf("v%0d_zero", idx), 32'(out_zero), 32'(v.zero));
    chk($sformatf("v%0d_neg", idx), 32'(out_neg), 32'(v.neg));
    chk($sformatf("v%0d_ovf", idx), 32'(out_ovf), 32'(v.ovf));
  endtask

  logic [15:0] sa[6];
  logic [15:0] sb[6];
  logic        sbin[6];

  initial begin
    int sent, ngot, cyc, stalls, seen;
    logic [16:0] d;

    vt[0]  = mk(16'h1234, 16'h0034, 1'b0, 1'b1, 16'h1200, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[1]  = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vt[2]  = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[3]  = mk(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vt[4]  = mk(16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[5]  = mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[6]  = mk(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    vt[7]  = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vt[8]  = mk(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[9]  = mk(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[10] = mk(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h4B4B, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[11] = mk(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      sa[i]   = 16'(16'h2000 * i + 16'h0050);
      sb[i]   = 16'(16'h0800 * i + 16'h0100);
      sbin[i] = 1'(i & 1);
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_bin = 1'b0; in_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_flags", 32'({out_bout, out_zero, out_neg, out_ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Streaming with out_ready low for cycles 5..7.
    drain();
    sent = 0; ngot = 0; cyc = 0; stalls = 0;
    while ((sent < 6 || ngot < 6) && cyc < 40) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 6) begin
        in_a = sa[sent]; in_b = sb[sent];
        in_bin = sbin[sent]; in_enable = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (!in_ready) stalls++;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (ngot < 6) begin
          d = {1'b0, sa[ngot]} - {1'b0, sb[ngot]} - 17'(sbin[ngot]);
          chk($sformatf("bp%0d_res", ngot), 32'(out_res), 32'(d[15:0]));
          chk($sformatf("bp%0d_bout", ngot), 32'(out_bout), 32'(d[16]));
        end
        ngot++;
      end
      cyc++;
    end
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_got", 32'(ngot), 32'd6);
    chk("bp_stalls", 32'(stalls), 32'd3);

    // Reset with three beats in flight.
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = vt[i+6].a; in_b = vt[i+6].b;
      in_bin = vt[i+6].bin; in_enable = 1'b1;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_res", 32'(out_res), 32'd0);
    chk("mid_rst_flags", 32'({out_bout, out_zero, out_neg, out_ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_ghost", 32'(seen), 32'd0);
    run_vec(vt[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
